// File: rtl/xadc_sample_packetizer_pkg.sv
// Shared types and constants for the XADC sample packetizer.
package teachee_defs;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned BYTE_WIDTH   = 8;

  localparam logic [BYTE_WIDTH-1:0] PACKET_HEADER_BYTE = 8'hA5;
  localparam int unsigned           PACKET_LEN_BYTES   = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_V_HI = 3'd3,
    ST_V_LO = 3'd4,
    ST_I_HI = 3'd5,
    ST_I_LO = 3'd6
  } xadc_packet_state_t;

  // One output beat: data byte plus end-of-packet marker.
  typedef struct packed {
    logic                  last;
    logic [BYTE_WIDTH-1:0] data;
  } packet_byte_t;

endpackage

// File: rtl/xadc_sample_packetizer_hold.sv
// axis_sample_hold: one-entry holding register for an AXI-Stream sample input.
// Ports: clk/rst (async active-low), enable (capture vs discard), clear (drop
// held sample), tdata/tvalid/tready sink handshake, avail_c/avail_data_c give
// the held sample, or the one being captured this cycle, to the consumer.
module axis_sample_hold #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] tdata,
  input  logic         tvalid,
  output logic         tready,
  output logic         avail_c,
  output logic [W-1:0] avail_data_c
);

  logic         hold_valid;
  logic [W-1:0] hold_data;
  logic         capture;

  assign capture = tvalid && tready && enable;

  // Bypass lets a sample captured this cycle complete a pair immediately.
  assign avail_c      = hold_valid || capture;
  assign avail_data_c = hold_valid ? hold_data : tdata;

  // tready is kept as its own flop, always the complement of hold_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      tready     <= 1'b1;
      hold_data  <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
      tready     <= 1'b1;
    end else if (capture) begin
      hold_valid <= 1'b1;
      tready     <= 1'b0;
      hold_data  <= tdata;
    end
  end

endmodule

// File: rtl/xadc_sample_packetizer.sv
// xadc_sample_packetizer: pairs voltage/current samples into 6-byte packets
// (A5, seq, V hi, V lo, I hi, I lo) on an 8-bit AXI-Stream with tlast.
// Ports: clk, rst (async active-low), enable, voltage_channel_* and
// current_monitor_channel_* 16-bit sinks, byte_stream_* 8-bit source.
module xadc_sample_packetizer
  import teachee_defs::*;
#(
  parameter logic [7:0]  HEADER_BYTE = PACKET_HEADER_BYTE,
  parameter int unsigned SEQ_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] voltage_channel_tdata,
  input  logic                    voltage_channel_tvalid,
  output logic                    voltage_channel_tready,
  input  logic [SAMPLE_WIDTH-1:0] current_monitor_channel_tdata,
  input  logic                    current_monitor_channel_tvalid,
  output logic                    current_monitor_channel_tready,
  output logic [BYTE_WIDTH-1:0]   byte_stream_tdata,
  output logic                    byte_stream_tvalid,
  input  logic                    byte_stream_tready,
  output logic                    byte_stream_tlast
);

  xadc_packet_state_t state_q, state_nxt;
  logic [SEQ_WIDTH-1:0]    seq_q, seq_nxt;
  logic [SAMPLE_WIDTH-1:0] pkt_v_q, pkt_i_q;
  logic                    out_valid_q, out_valid_nxt;
  packet_byte_t            out_q, out_nxt;

  logic                    v_avail, i_avail;
  logic [SAMPLE_WIDTH-1:0] v_avail_data, i_avail_data;
  logic                    pair_c, load, out_hs;

  axis_sample_hold #(.W(SAMPLE_WIDTH)) u_v_hold (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear        (load),
    .tdata        (voltage_channel_tdata),
    .tvalid       (voltage_channel_tvalid),
    .tready       (voltage_channel_tready),
    .avail_c      (v_avail),
    .avail_data_c (v_avail_data)
  );

  axis_sample_hold #(.W(SAMPLE_WIDTH)) u_i_hold (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear        (load),
    .tdata        (current_monitor_channel_tdata),
    .tvalid       (current_monitor_channel_tvalid),
    .tready       (current_monitor_channel_tready),
    .avail_c      (i_avail),
    .avail_data_c (i_avail_data)
  );

  assign pair_c = v_avail && i_avail;
  assign out_hs = out_valid_q && byte_stream_tready;

  assign byte_stream_tvalid = out_valid_q;
  assign byte_stream_tdata  = out_q.data;
  assign byte_stream_tlast  = out_q.last;

  // Next state and next output beat; the beat loaded here is what the
  // following state presents.
  always_comb begin
    state_nxt     = state_q;
    seq_nxt       = seq_q;
    out_valid_nxt = out_valid_q;
    out_nxt       = out_q;
    load          = 1'b0;
    unique case (state_q)
      ST_IDLE: if (pair_c) begin
        load          = 1'b1;
        state_nxt     = ST_HDR;
        out_valid_nxt = 1'b1;
        out_nxt       = '{last: 1'b0, data: HEADER_BYTE};
      end
      ST_HDR: if (out_hs) begin
        state_nxt = ST_SEQ;
        out_nxt   = '{last: 1'b0, data: BYTE_WIDTH'(seq_q)};
      end
      ST_SEQ: if (out_hs) begin
        state_nxt = ST_V_HI;
        out_nxt   = '{last: 1'b0, data: pkt_v_q[15:8]};
      end
      ST_V_HI: if (out_hs) begin
        state_nxt = ST_V_LO;
        out_nxt   = '{last: 1'b0, data: pkt_v_q[7:0]};
      end
      ST_V_LO: if (out_hs) begin
        state_nxt = ST_I_HI;
        out_nxt   = '{last: 1'b0, data: pkt_i_q[15:8]};
      end
      ST_I_HI: if (out_hs) begin
        state_nxt = ST_I_LO;
        out_nxt   = '{last: 1'b1, data: pkt_i_q[7:0]};
      end
      ST_I_LO: if (out_hs) begin
        seq_nxt = seq_q + SEQ_WIDTH'(1);
        if (pair_c) begin
          load      = 1'b1;
          state_nxt = ST_HDR;
          out_nxt   = '{last: 1'b0, data: HEADER_BYTE};
        end else begin
          state_nxt     = ST_IDLE;
          out_valid_nxt = 1'b0;
          out_nxt       = '0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        out_valid_nxt = 1'b0;
        out_nxt       = '0;
      end
    endcase
  end

  // State, sequence counter, packet registers and output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      pkt_v_q     <= '0;
      pkt_i_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_nxt;
      seq_q       <= seq_nxt;
      out_valid_q <= out_valid_nxt;
      out_q       <= out_nxt;
      if (load) begin
        pkt_v_q <= v_avail_data;
        pkt_i_q <= i_avail_data;
      end
    end
  end

endmodule
